// File: rtl/tone_generator.sv
// Square-wave tone generator: period counter driven by a divider latched at period
// boundaries, volume-scaled sample, and a 256-cycle-frame PWM encoder for the speaker pin.
module tone_generator #(
  parameter int DIV_W = 16,
  parameter int PWM_W = 8
) (
  input  logic             hz12M,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] divider,
  input  logic [3:0]       volume,
  output logic             wave,
  output logic [PWM_W-1:0] sample,
  output logic             pwm,
  output logic             period_tick,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty_q;

  logic             start;
  logic             wrap;
  logic [DIV_W-1:0] last_cnt;
  logic [DIV_W-1:0] half_div;

  assign start    = en && (divider >= DIV_W'(2));
  assign last_cnt = div_q - DIV_W'(1);
  assign half_div = div_q >> 1;
  assign wrap     = (state == RUN) && (cnt == last_cnt);

  // Outputs decode registers only, so an input glitch can never reach wave mid-period.
  assign busy        = (state == RUN);
  assign wave        = busy && (cnt < half_div);
  assign period_tick = wrap;
  assign sample      = wave ? {volume, volume} : '0;
  assign pwm         = (pwm_cnt < duty_q);

  always_ff @(posedge hz12M) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      div_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            div_q <= divider;
            state <= RUN;
          end
        end
        RUN: begin
          if (wrap) begin
            cnt <= '0;
            if (start) div_q <= divider;
            else       state <= IDLE;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Duty is captured only at the last cycle of a frame so each frame is a clean PWM period.
  always_ff @(posedge hz12M) begin
    if (reset) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (pwm_cnt == {PWM_W{1'b1}}) duty_q <= sample;
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
// Directed bench for tone_generator: per-cycle expected output vectors are queued by the
// stimulus process and popped/compared by an independent monitor on the falling edge.
module tb_tone_generator;

  logic        hz12M;
  logic        reset;
  logic        en;
  logic [15:0] divider;
  logic [3:0]  volume;
  logic        wave;
  logic [7:0]  sample;
  logic        pwm;
  logic        period_tick;
  logic        busy;

  // Entry layout: {pwm_chk, pwm, busy, wave, period_tick, sample[7:0]}
  logic [12:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;

  tone_generator #(.DIV_W(16), .PWM_W(8)) dut (
    .hz12M       (hz12M),
    .reset       (reset),
    .en          (en),
    .divider     (divider),
    .volume      (volume),
    .wave        (wave),
    .sample      (sample),
    .pwm         (pwm),
    .period_tick (period_tick),
    .busy        (busy)
  );

  // clock / watchdog
  initial hz12M = 1'b0;
  always #5 hz12M = ~hz12M;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  // monitor / scoreboard
  always @(negedge hz12M) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      logic [10:0] got;
      e   = exp_q.pop_front();
      got = {busy, wave, period_tick, sample};
      checks++;
      if (got !== e[10:0] || (e[12] && pwm !== e[11])) begin
        errors++;
        $display("FAIL outputs cycle %0d: got busy=%b wave=%b tick=%b sample=%h pwm=%b, required busy=%b wave=%b tick=%b sample=%h pwm=%s",
                 cyc_no, busy, wave, period_tick, sample, pwm,
                 e[10], e[9], e[8], e[7:0], e[12] ? (e[11] ? "1" : "0") : "any");
      end
    end
    cyc_no++;
  end

  // driver tasks
  task automatic cyc(input logic b, input logic w, input logic t, input logic [7:0] s,
                     input logic pc, input logic p);
    exp_q.push_back({pc, p, b, w, t, s});
    @(posedge hz12M); #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic period4_ff();
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic period5_ff();
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    // reset with a valid note pending: everything stays 0
    reset = 1'b1; en = 1'b1; divider = 16'd4; volume = 4'hF;
    @(posedge hz12M); #1;
    idle_cyc();
    idle_cyc();
    reset = 1'b0;
    idle_cyc();

    // even divider 4, volume F
    period4_ff();
    period4_ff();

    // mid-period change to 6 at cnt=1: current period stays 4
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    divider = 16'd6;
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    divider = 16'd5;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // odd divider 5, then queue divider 4 for the next period
    period5_ff();
    divider = 16'd4;
    period5_ff();

    // note-off at cnt=0; volume change mid-high-phase shows up in sample immediately
    en = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    volume = 4'h8;
    cyc(1'b1, 1'b1, 1'b0, 8'h88, 1'b0, 1'b0);
    volume = 4'hF;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    idle_cyc();
    idle_cyc();

    // dividers 1 and 0 are silence even with en high
    en = 1'b1; divider = 16'd1;
    idle_cyc();
    idle_cyc();
    divider = 16'd0;
    idle_cyc();
    idle_cyc();

    // reset mid-run, then restart one cycle after release
    divider = 16'd4;
    idle_cyc();
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    reset = 1'b0;
    idle_cyc();
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    en = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    idle_cyc();

    // PWM: long note (high for 30000 cycles) so sample is steady across frames.
    // Frame 0 duty 0; frame 1 duty 0x88=136 (c 256..391 high); volume->3 at c=300 only
    // affects frame 2: duty 0x33=51 (c 512..562 high); reset at c=530 forces pwm low.
    reset = 1'b1; en = 1'b1; divider = 16'd60000; volume = 4'h8;
    idle_cyc();
    reset = 1'b0;
    for (int c = 0; c <= 530; c++) begin
      logic       run;
      logic [7:0] s_exp;
      logic       p_exp;
      if (c == 300) volume = 4'h3;
      if (c == 530) reset = 1'b1;
      run   = (c >= 1);
      s_exp = !run ? 8'h00 : (c >= 300 ? 8'h33 : 8'h88);
      p_exp = (c >= 256 && c < 392) || (c >= 512 && c < 563);
      cyc(run, run, 1'b0, s_exp, 1'b1, p_exp);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // final report
    @(negedge hz12M); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_generator.md
# tone_generator

Consumes the 16-bit `divider` word from the note-selection logic, where a divider is one full audio period in `hz12M` cycles and a value below 2 means "no note". Produces a 50%-duty square wave at that period, a volume-scaled 8-bit sample, and a 1-bit PWM stream that drives the speaker pin. Divider changes take effect only at period boundaries. Note-off lets the current period finish, so the output never clicks mid-cycle.

## Interface
- `DIV_W`, 16: divider and period-counter width.
- `PWM_W`, 8: sample and PWM-counter width. Fixed at 8 in this design.

Ports:
- `hz12M` in 1: system clock, 12 MHz.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: note enable. Sampled only in IDLE and at period wrap.
- `divider` in DIV_W: period length in cycles. Values 0 and 1 mean silence.
- `volume` in 4: amplitude code. The high-phase sample is {volume, volume}.
- `wave` out 1: square-wave output.
- `sample` out PWM_W: `wave` ? {volume, volume} : 8'h00.
- `pwm` out 1: PWM-encoded `sample`.
- `period_tick` out 1: one-cycle pulse in the last cycle of each period.
- `busy` out 1: high while in state RUN.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN}.
  - `cnt` [DIV_W], the period counter.
  - `div_q` [DIV_W], the latched divider.
  - `pwm_cnt` [8].
  - `duty_q` [8].
- Define `start = en && (divider >= 2)`.
- IDLE:
  - `cnt` holds 0.
  - On a clock edge with `start`: `div_q` ← `divider`, `cnt` ← 0, `state` ← RUN.
- RUN:
  - While `cnt != div_q-1`: `cnt` ← `cnt`+1.
  - When `cnt == div_q-1` (wrap):
    - `cnt` ← 0.
    - If `start`: `div_q` ← `divider` and stay in RUN. The new divider applies to the next period.
    - Else: `state` ← IDLE.
  - Changes to `divider`, `en` or `volume`-independent inputs mid-period are ignored until the wrap.
- Output decode (from registers only; no input-to-`wave` combinational path):
  - `busy` = (`state` == RUN).
  - `wave` = `busy` && (`cnt` < (`div_q` >> 1)). High for floor(D/2) cycles, then low for D − floor(D/2) cycles.
  - `period_tick` = `busy` && (`cnt` == `div_q`−1).
  - `sample` = `wave` ? {`volume`, `volume`} : 0. `volume` is combinational here.
- PWM:
  - `pwm_cnt` free-runs 0..255 and wraps. Frame length is 256 cycles (46.875 kHz).
  - When `pwm_cnt` == 255: `duty_q` ← `sample`.
  - `pwm` = (`pwm_cnt` < `duty_q`). Duty 0 gives constant 0. Duty 255 gives 255 high cycles out of 256.
- Width rules:
  - `div_q`−1 and `div_q`>>1 are computed in DIV_W bits. No overflow is possible because `div_q` ≥ 2 whenever in RUN.
  - Maximum divider is 65535, giving a 183 Hz minimum tone.

## Timing
- Reset values:
  - `state` = IDLE.
  - `cnt`, `div_q`, `pwm_cnt`, `duty_q` = 0.
  - Therefore `wave`, `sample`, `pwm`, `period_tick`, `busy` are all 0.
- Reset asserted mid-RUN returns every register to its reset value at that edge. Reset overrides all other inputs.
- Start latency: `start` true at edge k (in IDLE) gives `busy` = 1, `cnt` = 0 and `wave` = 1 in the cycle after edge k.
- Period is exactly `div_q` cycles. `period_tick` fires once per period.
- Back-to-back periods have no gap. After a wrap with `start`, `cnt` = 0 in the next cycle.
- Stop: a wrap without `start` drops `busy` in the next cycle, and `wave` is already 0 at that point.
- `start` in the same cycle as a wrap-to-IDLE is impossible by definition, because the wrap itself samples `start`.
- PWM duty-change latency: a new `sample` is reflected in `pwm` at the next frame start. That is the cycle after `pwm_cnt` == 255, a delay of at most 256 cycles.
- Example: divider 45868 at 12 MHz gives 261.6 Hz (C low).

## Test plan
- Reset stimulus: assert `reset` with `en` = 1, `divider` = 4 → all outputs 0 while in reset. The first `busy` = 1 appears one cycle after `reset` deasserts.
- Even divider: `en` = 1, `divider` = 4, `volume` = F.
  - `wave` repeats 1,1,0,0.
  - `sample` repeats FF,FF,00,00.
  - `period_tick` is high on every 4th cycle, coincident with the second 0.
- Odd divider: `divider` = 5 → `wave` repeats 1,1,0,0,0. `period_tick` has a 5-cycle spacing.
- Mid-period change: start with `divider` = 4. Switch to 6 when `cnt` = 1 → the current period still ends after 4 cycles, and the next period is 6 cycles (1,1,1,0,0,0).
- Note-off: drop `en` (or set `divider` = 1) when `cnt` = 0 of a 4-cycle period → 4 more cycles of 1,1,0,0, then `busy` = 0 and `wave` = 0. No new period starts.
- PWM: hold `volume` = 8 (sample 88 during the high phase), or force a steady duty.
  - `pwm` is high for exactly `duty_q` cycles of each 256-cycle frame.
  - A `sample` change mid-frame takes effect only in the following frame.
  - Reset mid-frame drives `pwm` to 0 immediately.
